// File: rtl/output_vc_tracker.sv
// rtl/output_vc_tracker.sv - per-output-VC state and downstream credit tracker
//
// Tracks IDLE/ACTIVE/DRAINING state and the downstream credit count of every
// output VC of the router, and publishes allocator-facing status vectors.
//
// Ports:
//   clk             rising-edge clock
//   reset           asynchronous active-low reset
//   vc_alloc        VC-allocation grants, bit p*NUM_VC+v = port p, VC v
//   flit_sent       a flit leaves output port p this cycle
//   flit_sent_vc    output VC of that flit, per port
//   flit_sent_tail  that flit is a tail (or single-flit packet)
//   credit_valid    downstream returns one credit on port p
//   credit_vc       VC of the returned credit, per port
//   vc_availability 1 = VC is IDLE (same ordering as vc_alloc)
//   vc_has_credit   1 = credit count non-zero
//   error           sticky protocol-error flag

module output_vc_tracker #(
    parameter int NUM_PORTS    = 5,
    parameter int NUM_VC       = 4,
    parameter int BUFFER_DEPTH = 4,
    parameter int VC_BITS      = $clog2(NUM_VC),
    parameter int CREDIT_BITS  = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_VC*NUM_PORTS-1:0]          vc_alloc,
    input  logic [NUM_PORTS-1:0]                 flit_sent,
    input  logic [NUM_PORTS-1:0][VC_BITS-1:0]    flit_sent_vc,
    input  logic [NUM_PORTS-1:0]                 flit_sent_tail,
    input  logic [NUM_PORTS-1:0]                 credit_valid,
    input  logic [NUM_PORTS-1:0][VC_BITS-1:0]    credit_vc,
    output logic [NUM_VC*NUM_PORTS-1:0]          vc_availability,
    output logic [NUM_VC*NUM_PORTS-1:0]          vc_has_credit,
    output logic                                 error
);

    localparam int NUM_OVC = NUM_VC * NUM_PORTS;
    localparam logic [CREDIT_BITS-1:0] CREDIT_FULL = CREDIT_BITS'(BUFFER_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_DRAINING = 2'd2
    } vc_state_t;

    logic [NUM_OVC-1:0] w_err_vec;
    logic               r_error;

    for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_port
        for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_vc
            localparam int IDX = gp * NUM_VC + gv;

            vc_state_t              r_state;
            logic [CREDIT_BITS-1:0] r_count;
            vc_state_t              w_state_next;
            logic [CREDIT_BITS-1:0] w_count_next;
            logic                   w_sent;
            logic                   w_tail;
            logic                   w_ret;
            logic                   w_alloc;
            logic                   w_credit_err;
            logic                   w_proto_err;

            assign w_sent  = flit_sent[gp] && (flit_sent_vc[gp] == VC_BITS'(gv));
            assign w_tail  = w_sent && flit_sent_tail[gp];
            assign w_ret   = credit_valid[gp] && (credit_vc[gp] == VC_BITS'(gv));
            assign w_alloc = vc_alloc[IDX];

            // A send and a return in the same cycle cancel, so saturation
            // checks only apply when exactly one of them is present.
            always_comb begin
                w_count_next = r_count;
                w_credit_err = 1'b0;
                if (w_sent && !w_ret) begin
                    if (r_count == '0) begin
                        w_credit_err = 1'b1;
                    end else begin
                        w_count_next = r_count - CREDIT_BITS'(1);
                    end
                end else if (w_ret && !w_sent) begin
                    if (r_count == CREDIT_FULL) begin
                        w_credit_err = 1'b1;
                    end else begin
                        w_count_next = r_count + CREDIT_BITS'(1);
                    end
                end
            end

            // State decisions look at the post-update count so that the last
            // returning credit and a tail in the same cycle free the VC at once.
            always_comb begin
                w_state_next = r_state;
                w_proto_err  = 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (w_alloc) begin
                            w_state_next = ST_ACTIVE;
                        end
                        if (w_sent) begin
                            w_proto_err = 1'b1;
                        end
                    end
                    ST_ACTIVE: begin
                        if (w_alloc) begin
                            w_proto_err = 1'b1;
                        end
                        if (w_tail) begin
                            w_state_next = (w_count_next == CREDIT_FULL) ? ST_IDLE : ST_DRAINING;
                        end
                    end
                    ST_DRAINING: begin
                        if (w_alloc || w_sent || w_tail) begin
                            w_proto_err = 1'b1;
                        end
                        if (w_count_next == CREDIT_FULL) begin
                            w_state_next = ST_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = ST_IDLE;
                    end
                endcase
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_state <= ST_IDLE;
                    r_count <= CREDIT_FULL;
                end else begin
                    r_state <= w_state_next;
                    r_count <= w_count_next;
                end
            end

            assign vc_availability[IDX] = (r_state == ST_IDLE);
            assign vc_has_credit[IDX]   = (r_count != '0);
            assign w_err_vec[IDX]       = w_credit_err | w_proto_err;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_error <= 1'b0;
        end else if (|w_err_vec) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;

endmodule

// File: tb/tb_output_vc_tracker.sv
// tb/tb_output_vc_tracker.sv - scoreboard testbench for output_vc_tracker

module tb_output_vc_tracker;

    localparam int VB = 2;
    localparam logic [19:0] ONES = 20'hFFFFF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [19:0]      vc_alloc;
    logic [4:0]       flit_sent;
    logic [4:0][1:0]  flit_sent_vc;
    logic [4:0]       flit_sent_tail;
    logic [4:0]       credit_valid;
    logic [4:0][1:0]  credit_vc;
    logic [19:0]      vc_availability;
    logic [19:0]      vc_has_credit;
    logic             error;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string       tag;
        logic [19:0] av;
        logic [19:0] cr;
        logic        er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    output_vc_tracker dut (
        .clk            (clk),
        .reset          (reset),
        .vc_alloc       (vc_alloc),
        .flit_sent      (flit_sent),
        .flit_sent_vc   (flit_sent_vc),
        .flit_sent_tail (flit_sent_tail),
        .credit_valid   (credit_valid),
        .credit_vc      (credit_vc),
        .vc_availability(vc_availability),
        .vc_has_credit  (vc_has_credit),
        .error          (error)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] b(input int i);
        logic [19:0] one;
        one = 20'd1;
        return one << i;
    endfunction

    task automatic clear_inputs();
        vc_alloc       = '0;
        flit_sent      = '0;
        flit_sent_vc   = '0;
        flit_sent_tail = '0;
        credit_valid   = '0;
        credit_vc      = '0;
    endtask

    task automatic set_alloc(input int i);
        vc_alloc[i] = 1'b1;
    endtask

    task automatic set_send(input int p, input int v, input logic tail);
        flit_sent[p]      = 1'b1;
        flit_sent_vc[p]   = VB'(v);
        flit_sent_tail[p] = tail;
    endtask

    task automatic set_ret(input int p, input int v);
        credit_valid[p] = 1'b1;
        credit_vc[p]    = VB'(v);
    endtask

    // Inputs are set by the caller; the expectation for the state after the
    // next rising edge is queued, then inputs are cleared after that edge.
    task automatic tick(input string tag, input logic [19:0] av, input logic [19:0] cr, input logic er);
        exp_t e;
        e.tag = tag;
        e.av  = av;
        e.cr  = cr;
        e.er  = er;
        sb.push_back(e);
        @(posedge clk);
        #2;
        clear_inputs();
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk({mon_e.tag, "/avail"},  32'(vc_availability), 32'(mon_e.av));
            chk({mon_e.tag, "/credit"}, 32'(vc_has_credit),   32'(mon_e.cr));
            chk({mon_e.tag, "/error"},  32'(error),           32'(mon_e.er));
        end
    end

    // Asserts reset away from any clock edge and checks outputs before the
    // next edge arrives, then releases on a falling edge.
    task automatic async_reset_check(input string tag);
        reset = 1'b0;
        #1;
        chk({tag, "/avail"},  32'(vc_availability), 32'(ONES));
        chk({tag, "/credit"}, 32'(vc_has_credit),   32'(ONES));
        chk({tag, "/error"},  32'(error),           32'd0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        #1;
        async_reset_check("reset_init");
        repeat (2) @(negedge clk);

        // Single-flit packet on port 2 VC1 (bit 9)
        set_alloc(9);
        tick("grant9", ONES & ~b(9), ONES, 1'b0);
        tick("hold9",  ONES & ~b(9), ONES, 1'b0);
        set_send(2, 1, 1'b1);
        tick("tail9",  ONES & ~b(9), ONES, 1'b0);
        tick("drain9", ONES & ~b(9), ONES, 1'b0);
        set_ret(2, 1);
        tick("credit9", ONES, ONES, 1'b0);

        // Credit exhaustion on port 0 VC0 (bit 0)
        set_alloc(0);
        tick("grant0", ONES & ~b(0), ONES, 1'b0);
        for (int k = 0; k < 3; k++) begin
            set_send(0, 0, 1'b0);
            tick("body0", ONES & ~b(0), ONES, 1'b0);
        end
        set_send(0, 0, 1'b0);
        tick("body0_last", ONES & ~b(0), ONES & ~b(0), 1'b0);
        set_send(0, 0, 1'b0);
        set_ret(0, 0);
        tick("sendret_at0", ONES & ~b(0), ONES & ~b(0), 1'b0);

        // Tail and return together with the VC at full credit: straight to IDLE
        set_alloc(6);
        tick("grant6", ONES & ~b(0) & ~b(6), ONES & ~b(0), 1'b0);
        set_send(1, 2, 1'b1);
        set_ret(1, 2);
        tick("tailret6", ONES & ~b(0), ONES & ~b(0), 1'b0);

        // Underflow: count saturates at 0, then one return gives a count of 1
        set_send(0, 0, 1'b0);
        tick("underflow0", ONES & ~b(0), ONES & ~b(0), 1'b1);
        set_ret(0, 0);
        tick("ret_after_uf", ONES & ~b(0), ONES, 1'b1);
        set_send(0, 0, 1'b0);
        tick("resend_to0", ONES & ~b(0), ONES & ~b(0), 1'b1);

        async_reset_check("reset_midrun");

        // Grant to an ACTIVE VC
        set_alloc(5);
        tick("grant5", ONES & ~b(5), ONES, 1'b0);
        set_alloc(5);
        tick("regrant5", ONES & ~b(5), ONES, 1'b1);

        async_reset_check("reset_after_err");

        // Overflow on a full IDLE VC: count must stay 4, proven by 4 sends
        set_ret(4, 3);
        tick("overflow19", ONES, ONES, 1'b1);
        set_alloc(19);
        tick("grant19", ONES & ~b(19), ONES, 1'b1);
        for (int k = 0; k < 3; k++) begin
            set_send(4, 3, 1'b0);
            tick("body19", ONES & ~b(19), ONES, 1'b1);
        end
        set_send(4, 3, 1'b0);
        tick("body19_last", ONES & ~b(19), ONES & ~b(19), 1'b1);

        @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
